imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 191 +++++++++++++++++++
 tb/tb_imem_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: assembles a byte stream into 32-bit instruction writes and sequences core reset.
// Define IMEM_LOADER_CHECKSUM_EN to check a trailing XOR checksum byte before releasing the core.
module imem_loader #(
  parameter int         CLEAR_CYCLES = 2,
  parameter logic [9:0] START_PC     = 10'd1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_load,
  input  logic [9:0]  load_words,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        reset_IF_memory,
  output logic        core_reset,
  output logic        imem_we,
  output logic [9:0]  PC_write,
  output logic [31:0] instruction_in,
  output logic        busy,
  output logic        error
);

  localparam int CW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_CHECK,
    S_RUN,
    S_ERROR
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t LOAD_EXIT = S_CHECK;
`else
  localparam state_t LOAD_EXIT = S_RUN;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] clr_cnt_q, clr_cnt_d;
  logic [9:0]    words_q, words_d;
  logic [9:0]    addr_q, addr_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [23:0]   word_q, word_d;
  logic          byte_ready_q, byte_ready_d;
  logic          rim_q, rim_d;
  logic          core_reset_q, core_reset_d;
  logic          imem_we_q, imem_we_d;
  logic [9:0]    pc_write_q, pc_write_d;
  logic [31:0]   instr_q, instr_d;
  logic          busy_q, busy_d;
  logic          accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    ck_q, ck_d;
  logic          error_q, error_d;
`endif

  assign accept = byte_valid && byte_ready_q;

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    words_d    = words_q;
    addr_d     = addr_q;
    bcnt_d     = bcnt_q;
    word_d     = word_q;
    imem_we_d  = 1'b0;
    pc_write_d = pc_write_q;
    instr_d    = instr_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    ck_d       = ck_q;
`endif
    unique case (state_q)
      S_IDLE, S_RUN, S_ERROR: begin
        if (start_load) begin
          state_d   = S_CLEAR;
          clr_cnt_d = '0;
          words_d   = load_words;
          addr_d    = START_PC;
          bcnt_d    = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          ck_d      = '0;
`endif
        end
      end
      S_CLEAR: begin
        if (clr_cnt_q == CLR_LAST) begin
          state_d = (words_q == '0) ? LOAD_EXIT : S_LOAD;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      S_LOAD: begin
        // words_q hits zero on the final byte; exit after its write strobe
        if (words_q == '0) begin
          state_d = LOAD_EXIT;
        end else if (accept) begin
          bcnt_d = bcnt_q + 2'd1;
          word_d = {byte_data, word_q[23:8]};
`ifdef IMEM_LOADER_CHECKSUM_EN
          ck_d   = ck_q ^ byte_data;
`endif
          if (bcnt_q == 2'd3) begin
            imem_we_d  = 1'b1;
            pc_write_d = addr_q;
            instr_d    = {byte_data, word_q};
            addr_d     = addr_q + 10'd1;
            words_d    = words_q - 10'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (words_q == 10'd1) state_d = S_CHECK;
`endif
          end
        end
      end
      S_CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (accept) state_d = (byte_data == ck_q) ? S_RUN : S_ERROR;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    byte_ready_d = ((state_d == S_LOAD) && (words_d != '0)) ||
                   (state_d == S_CHECK);
    rim_d        = (state_d == S_CLEAR);
    core_reset_d = (state_d != S_RUN);
    busy_d       = (state_d == S_CLEAR) || (state_d == S_LOAD) ||
                   (state_d == S_CHECK);
`ifdef IMEM_LOADER_CHECKSUM_EN
    error_d      = (state_d == S_ERROR);
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      clr_cnt_q    <= '0;
      words_q      <= '0;
      addr_q       <= START_PC;
      bcnt_q       <= '0;
      word_q       <= '0;
      byte_ready_q <= 1'b0;
      rim_q        <= 1'b1;
      core_reset_q <= 1'b1;
      imem_we_q    <= 1'b0;
      pc_write_q   <= START_PC;
      instr_q      <= '0;
      busy_q       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      ck_q         <= '0;
      error_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      words_q      <= words_d;
      addr_q       <= addr_d;
      bcnt_q       <= bcnt_d;
      word_q       <= word_d;
      byte_ready_q <= byte_ready_d;
      rim_q        <= rim_d;
      core_reset_q <= core_reset_d;
      imem_we_q    <= imem_we_d;
      pc_write_q   <= pc_write_d;
      instr_q      <= instr_d;
      busy_q       <= busy_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      ck_q         <= ck_d;
      error_q      <= error_d;
`endif
    end
  end

  assign byte_ready      = byte_ready_q;
  assign reset_IF_memory = rim_q;
  assign core_reset      = core_reset_q;
  assign imem_we         = imem_we_q;
  assign PC_write        = pc_write_q;
  assign instruction_in  = instr_q;
  assign busy            = busy_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign error           = error_q;
`else
  assign error           = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: random and directed loads checked against a queue-based write model.
// Two instances share stimulus: START_PC=1 and START_PC=1023 (address wrap).
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_load;
  logic [9:0]  load_words;
  logic        byte_valid;
  logic [7:0]  byte_data;

  logic        a_ready, a_rim, a_cr, a_we, a_busy, a_err;
  logic [9:0]  a_pc;
  logic [31:0] a_w;
  logic        b_ready, b_rim, b_cr, b_we, b_busy, b_err;
  logic [9:0]  b_pc;
  logic [31:0] b_w;

  imem_loader dut_a (
    .clock(clock), .reset(reset), .start_load(start_load),
    .load_words(load_words), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(a_ready), .reset_IF_memory(a_rim), .core_reset(a_cr),
    .imem_we(a_we), .PC_write(a_pc), .instruction_in(a_w),
    .busy(a_busy), .error(a_err)
  );

  imem_loader #(.START_PC(10'd1023)) dut_b (
    .clock(clock), .reset(reset), .start_load(start_load),
    .load_words(load_words), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(b_ready), .reset_IF_memory(b_rim), .core_reset(b_cr),
    .imem_we(b_we), .PC_write(b_pc), .instruction_in(b_w),
    .busy(b_busy), .error(b_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [9:0]  pc;
    logic [31:0] w;
  } wr_t;

  int          errs = 0;
  int          checks = 0;
  wr_t         cap_a[$];
  wr_t         cap_b[$];
  int          cyc = 0;
  int          rim_cnt = 0;
  int          acc_bytes = 0;
  int          last_we_cyc = -1;
  int          cr_fall_cyc = -1;
  logic        cr_prev = 1'b1;
  logic        we_prev = 1'b0;
  logic [9:0]  hold_pc = 10'd1;
  logic [31:0] hold_w = '0;
  logic [7:0]  q[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    cyc++;
    if (a_we) begin
      cap_a.push_back('{a_pc, a_w});
      last_we_cyc = cyc;
      chk("we_whole_word", 64'(acc_bytes % 4), 64'd0);
      chk("we_single_cycle", 64'(we_prev), 64'd0);
    end
    if (b_we) cap_b.push_back('{b_pc, b_w});
    if (reset) begin
      hold_pc = 10'd1;
      hold_w  = '0;
    end else if (a_we) begin
      hold_pc = a_pc;
      hold_w  = a_w;
    end else begin
      chk("hold_pc_instr", {a_pc, a_w}, {hold_pc, hold_w});
    end
    if (!reset && a_rim) rim_cnt++;
    if (byte_valid && a_ready) acc_bytes++;
    if (cr_prev && !a_cr) cr_fall_cyc = cyc;
    cr_prev = a_cr;
    we_prev = a_we;
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  function automatic logic [7:0] xor_of(input logic [7:0] d[$]);
    logic [7:0] x = '0;
    foreach (d[i]) x ^= d[i];
    return x;
  endfunction
`endif

  task automatic feed_bytes(input logic [7:0] s[$], input bit toggle,
                            input int pulse_at);
    int idx = 0;
    int budget = 400;
    bit acc_now;
    while (idx < s.size() && budget > 0) begin
      byte_valid = toggle ? budget[0] : 1'b1;
      byte_data  = s[idx];
      start_load = (idx == pulse_at);
      acc_now    = byte_valid && a_ready;
      @(posedge clock);
      #1;
      if (acc_now) idx++;
      budget--;
    end
    byte_valid = 1'b0;
    start_load = 1'b0;
    chk("bytes_fed", 64'(idx), 64'(s.size()));
  endtask

  task automatic begin_load(input int n);
    cap_a.delete();
    cap_b.delete();
    rim_cnt     = 0;
    acc_bytes   = 0;
    last_we_cyc = -1;
    cr_fall_cyc = -1;
    start_load  = 1'b1;
    load_words  = 10'(n);
    @(posedge clock);
    #1;
    start_load  = 1'b0;
  endtask

  task automatic do_load(input int n, input logic [7:0] data[$],
                         input bit toggle, input int pulse_at);
    logic [7:0]  s[$];
    logic [31:0] exp_w;
    int          budget = 50;
    s = data;
`ifdef IMEM_LOADER_CHECKSUM_EN
    s.push_back(xor_of(data));
`endif
    begin_load(n);
    feed_bytes(s, toggle, pulse_at);
    while (a_cr && budget > 0) begin
      @(posedge clock);
      #1;
      budget--;
    end
    chk("run_reached", 64'(budget > 0), 64'd1);
    repeat (2) @(posedge clock);
    #1;
    chk("clear_cycles", 64'(rim_cnt), 64'd2);
    chk("writes_a", 64'(cap_a.size()), 64'(n));
    chk("writes_b", 64'(cap_b.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      exp_w = {data[4*i+3], data[4*i+2], data[4*i+1], data[4*i]};
      if (i < cap_a.size()) begin
        chk("pc_a", 64'(cap_a[i].pc), 64'((1 + i) % 1024));
        chk("word_a", 64'(cap_a[i].w), 64'(exp_w));
      end
      if (i < cap_b.size()) begin
        chk("pc_b", 64'(cap_b[i].pc), 64'((1023 + i) % 1024));
        chk("word_b", 64'(cap_b[i].w), 64'(exp_w));
      end
    end
    chk("run_core_reset", 64'(a_cr), 64'd0);
    chk("run_busy", 64'(a_busy), 64'd0);
    chk("run_error", 64'(a_err), 64'd0);
`ifndef IMEM_LOADER_CHECKSUM_EN
    if (n > 0) chk("cr_fall_lag", 64'(cr_fall_cyc - last_we_cyc), 64'd1);
`endif
  endtask

  initial begin
    int n;
    reset      = 1'b1;
    start_load = 1'b0;
    load_words = '0;
    byte_valid = 1'b0;
    byte_data  = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ready", 64'(a_ready), 64'd0);
    chk("rst_rim", 64'(a_rim), 64'd1);
    chk("rst_core_reset", 64'(a_cr), 64'd1);
    chk("rst_pc_b", 64'(b_pc), 64'd1023);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("rim_released", 64'(a_rim), 64'd0);

    q = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hCB, 8'hAB};
    do_load(2, q, 1'b0, -1);
    do_load(2, q, 1'b1, -1);

    q = {8'h01, 8'h02};
    begin_load(2);
    feed_bytes(q, 1'b0, -1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("mid_rst_ready", 64'(a_ready), 64'd0);
    chk("mid_rst_we", 64'(a_we), 64'd0);
    chk("mid_rst_rim", 64'(a_rim), 64'd1);
    chk("mid_rst_core_reset", 64'(a_cr), 64'd1);
    chk("mid_rst_pc", 64'(a_pc), 64'd1);
    chk("mid_rst_instr", 64'(a_w), 64'd0);
    chk("mid_rst_busy", 64'(a_busy), 64'd0);
    chk("mid_rst_error", 64'(a_err), 64'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("mid_rst_rim_low", 64'(a_rim), 64'd0);
    q = {8'h78, 8'h56, 8'h34, 8'h12};
    do_load(1, q, 1'b0, -1);

    q.delete();
    do_load(0, q, 1'b0, -1);

    for (int k = 0; k < 8; k++) q.push_back(8'($urandom));
    do_load(2, q, 1'b0, 3);

    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(1, 5));
      q.delete();
      for (int j = 0; j < 4 * n; j++) q.push_back(8'($urandom));
      do_load(n, q, 1'($urandom_range(0, 1)), -1);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    q = {8'h11, 8'h11, 8'h11, 8'h11};
    do_load(1, q, 1'b0, -1);
    begin_load(1);
    q.push_back(8'h01);
    feed_bytes(q, 1'b0, -1);
    repeat (3) @(posedge clock);
    #1;
    chk("ck_bad_error", 64'(a_err), 64'd1);
    chk("ck_bad_core_reset", 64'(a_cr), 64'd1);
    start_load = 1'b1;
    @(posedge clock);
    #1;
    start_load = 1'b0;
    chk("ck_restart_rim", 64'(a_rim), 64'd1);
    chk("ck_restart_error", 64'(a_err), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
